ram: RTL and testbench
======================

# ram

Single-port, parameterised random-access memory with a synchronous write and a combinational (asynchronous) read. It provides a word-addressed register file of 2^ADDRESS_WIDTH words, each BUS_WIDTH bits wide. It is the basic storage element in the memory subsystem and is used directly by datapath blocks that need small addressable storage.

## Interface

Parameters:
- BUS_WIDTH, default 8: word width in bits; applies to both data in and data out.
- ADDRESS_WIDTH, default 2: address width in bits; depth is 2^ADDRESS_WIDTH words.

Ports:
- clk  input  1  clock; all writes occur on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears every word to 0.
- ad  input  ADDRESS_WIDTH  word address, used for both read and write.
- st  input  1  store enable; 1 means write X into word ad on the clk rising edge.
- X  input  BUS_WIDTH  write data.
- O  output  BUS_WIDTH  read data, always the current content of word ad.

Port declaration order is fixed as ad, st, X, clk, O, rst. Existing 5-port positional instantiations therefore stay valid.

## Operation

- Storage: array of 2^ADDRESS_WIDTH words of BUS_WIDTH bits.
- Address decode: full decode with no out-of-range case, since every ad value is a valid word.
- Write:
  - On a clk rising edge with rst=0 and st=1, word[ad] <= X.
  - With st=0, no word changes.
  - Only the addressed word is modified.
- Read:
  - O = word[ad], combinational.
  - A change of ad alone updates O with no clock edge needed.
- Reset:
  - While rst=1, all words are held at 0 and writes are ignored.
  - O therefore reads 0 at every address.
- Holding clk high or low, or changing X or st between edges, never modifies memory. Only rising edges write.

## Timing

- Write latency: the new value is visible on O immediately after the clk rising edge that stores it, in the same delta/cycle.
- Read latency: zero cycles, combinational from ad and memory contents.
- Read-during-write to the same address:
  - Before the edge, O shows the old value.
  - After the edge, O shows the new value (write-first at the edge).
- X and st are sampled only at the clk rising edge. Setup/hold are relative to that edge.
- Reset:
  - Asynchronous assertion clears all words without a clock.
  - Deassertion takes effect on the next rising edge.
  - A write on an edge coinciding with rst=1 is discarded.
- Reset mid-operation: any write in progress is lost and all contents become 0.
- Output value after reset: O = 0.

## Test plan

- Reset: assert rst, sweep ad over 0..3 -> O = 0 at every address. Deassert, sweep again -> still 0.
- Basic write/hold at ad=2, st=1:
  - X=1 with clk low -> O stays 0.
  - clk rises -> O=1.
  - X=30 while clk stays high -> O=1.
  - clk falls with X=31 -> O=1.
  - clk rises with X=32 -> O=32.
  - X=33 with no new edge -> O=32.
  - st=0, X=15, clk edge -> O=32.
- Independent words at ad=3, st=1:
  - clk rises with X=1 -> O=1.
  - X=40 with no edge -> O=1.
  - Next rising edge with X=42 -> O=42.
  - Then ad=2 with st=0 -> O=32, and clock edges with X=20/21 leave O=32.
  - ad=3 -> O=42.
- Combinational read: change ad between 2 and 3 with clk static -> O switches between 32 and 42 with no edge.
- Reset mid-operation:
  - Write 0xA5 to ad=1, then assert rst asynchronously between edges -> O=0 immediately.
  - Apply a rising edge with st=1, X=0x11 while rst=1 -> word stays 0.
- Parameter check: BUS_WIDTH=16, ADDRESS_WIDTH=4.
  - Write 0xBEEF to ad=15 and 0x1234 to ad=0 -> each reads back intact.
  - Other addresses still read 0 after reset.

Source files
------------

// File: rtl/ram.sv
// Single-port word-addressed RAM: writes on the rising clock edge, reads combinationally.
// An asynchronous active-high reset clears every word to zero.
module ram #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic [ADDRESS_WIDTH-1:0] ad,
    input  logic                     st,
    input  logic [BUS_WIDTH-1:0]     X,
    input  logic                     clk,
    output logic [BUS_WIDTH-1:0]     O,
    input  logic                     rst
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [BUS_WIDTH-1:0] mem [DEPTH];

    // Reset wins over any coincident write, so a store on a reset edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (st) begin
            mem[ad] <= X;
        end
    end

    // Read path has no register: a new address or a fresh write shows up at once.
    assign O = mem[ad];

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: default 8x4 instance plus a 16-bit x 16-word instance.
// Clock edges are placed by hand so hold/no-edge behaviour can be exercised.
module tb_ram;

    logic        clk;
    logic        rst;
    logic [1:0]  ad;
    logic        st;
    logic [7:0]  x;
    logic [7:0]  o;
    logic [3:0]  ad2;
    logic        st2;
    logic [15:0] x2;
    logic [15:0] o2;

    int n_cmp;
    int n_bad;

    ram dut (
        .ad (ad),
        .st (st),
        .X  (x),
        .clk(clk),
        .O  (o),
        .rst(rst)
    );

    ram #(.BUS_WIDTH(16), .ADDRESS_WIDTH(4)) dut_wide (
        .ad (ad2),
        .st (st2),
        .X  (x2),
        .clk(clk),
        .O  (o2),
        .rst(rst)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rise();
        clk = 1'b1;
        #1;
    endtask

    task automatic fall();
        clk = 1'b0;
        #1;
    endtask

    task automatic cycle();
        fall();
        rise();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk = 1'b0;
        rst = 1'b1;
        ad = '0; st = 1'b0; x = '0;
        ad2 = '0; st2 = 1'b0; x2 = '0;
        #1;

        // Reset held: every address reads zero
        for (int a = 0; a < 4; a++) begin
            ad = 2'(a);
            #1;
            check($sformatf("rst_sweep_ad%0d", a), {8'h0, o}, 16'h0);
        end
        rst = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            ad = 2'(a);
            #1;
            check($sformatf("post_rst_ad%0d", a), {8'h0, o}, 16'h0);
        end

        // Basic write/hold at ad=2
        ad = 2'd2; st = 1'b1; x = 8'd1;
        #1; check("x1_clk_low", {8'h0, o}, 16'd0);
        rise(); check("x1_rise", {8'h0, o}, 16'd1);
        x = 8'd30; #1; check("x30_clk_high", {8'h0, o}, 16'd1);
        x = 8'd31; fall(); check("x31_fall", {8'h0, o}, 16'd1);
        x = 8'd32; rise(); check("x32_rise", {8'h0, o}, 16'd32);
        x = 8'd33; #1; check("x33_no_edge", {8'h0, o}, 16'd32);
        st = 1'b0; x = 8'd15; cycle(); check("st0_edge", {8'h0, o}, 16'd32);

        // Independent word at ad=3
        ad = 2'd3; st = 1'b1; x = 8'd1; cycle(); check("ad3_x1", {8'h0, o}, 16'd1);
        x = 8'd40; #1; check("ad3_x40_no_edge", {8'h0, o}, 16'd1);
        fall(); x = 8'd42; rise(); check("ad3_x42", {8'h0, o}, 16'd42);
        ad = 2'd2; st = 1'b0; #1; check("ad2_kept", {8'h0, o}, 16'd32);
        x = 8'd20; cycle();
        x = 8'd21; cycle(); check("ad2_st0_edges", {8'h0, o}, 16'd32);
        ad = 2'd3; #1; check("ad3_kept", {8'h0, o}, 16'd42);

        // Combinational read with clock static
        ad = 2'd2; #1; check("comb_ad2", {8'h0, o}, 16'd32);
        ad = 2'd3; #1; check("comb_ad3", {8'h0, o}, 16'd42);
        ad = 2'd0; #1; check("comb_ad0", {8'h0, o}, 16'd0);

        // Reset mid-operation
        ad = 2'd1; st = 1'b1; x = 8'hA5; cycle(); check("ad1_a5", {8'h0, o}, 16'h00A5);
        st = 1'b0; fall();
        rst = 1'b1; #1; check("async_rst_ad1", {8'h0, o}, 16'h0);
        ad = 2'd3; #1; check("async_rst_ad3", {8'h0, o}, 16'h0);
        ad = 2'd1; st = 1'b1; x = 8'h11; rise(); check("write_during_rst", {8'h0, o}, 16'h0);
        st = 1'b0; fall();
        rst = 1'b0; #1; check("after_rst_ad1", {8'h0, o}, 16'h0);

        // Wide instance
        st2 = 1'b1; ad2 = 4'd15; x2 = 16'hBEEF; cycle();
        fall(); ad2 = 4'd0; x2 = 16'h1234; rise();
        st2 = 1'b0; fall();
        ad2 = 4'd15; #1; check("wide_ad15", o2, 16'hBEEF);
        ad2 = 4'd0;  #1; check("wide_ad0", o2, 16'h1234);
        ad2 = 4'd5;  #1; check("wide_ad5", o2, 16'h0);
        ad2 = 4'd14; #1; check("wide_ad14", o2, 16'h0);
        ad = 2'd2;   #1; check("narrow_untouched", {8'h0, o}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
